// File: rtl/bus_terminal_fifo.sv
// Per-terminal TX/RX packet buffering between a host port and one bus driver slot.
// Optional drop statistics counters are built when BUS_FIFO_STATS_EN is defined.

module bus_terminal_fifo_q #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          nonempty,
    output logic [W-1:0]  head,
    output logic          ovf,
    output logic [15:0]   drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic          rd_ok_s;
    logic          wr_ok_s;
    logic          drop_s;
    logic [CW-1:0] count_nxt_s;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    // Accept/drop decisions; a pop in the same cycle frees a slot for a write into a full queue.
    always_comb begin
        rd_ok_s     = 1'b0;
        wr_ok_s     = 1'b0;
        drop_s      = 1'b0;
        count_nxt_s = count_r;
        rd_ok_s     = rd && (count_r != {CW{1'b0}});
        wr_ok_s     = wr && ((count_r != FULL_CNT) || rd_ok_s);
        drop_s      = wr && !wr_ok_s;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (rd_ok_s) rd_ptr_r <= next_ptr(rd_ptr_r);
            count_r <= count_nxt_s;
            if (drop_s) ovf_r <= 1'b1;
        end
    end

    // Packet storage; contents are never cleared, the head is masked when empty instead.
    always_ff @(posedge clk) begin
        if (reset && wr_ok_s) mem_r[wr_ptr_r] <= wdata;
    end

`ifdef BUS_FIFO_STATS_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of dropped writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign full     = (count_r == FULL_CNT);
    assign count    = count_r;
    assign nonempty = (count_r != {CW{1'b0}});
    assign head     = nonempty ? mem_r[rd_ptr_r] : {W{1'b0}};
    assign ovf      = ovf_r;
endmodule

module bus_terminal_fifo #(
    parameter int   pckg_sz   = 16,
    parameter int   deep_fifo = 8,
    localparam int  cnt_w     = $clog2(deep_fifo) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    output logic [cnt_w-1:0]   tx_count,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic [cnt_w-1:0]   rx_count,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic [15:0]        tx_drop_cnt,
    output logic [15:0]        rx_drop_cnt
);
    logic rx_full_s;

    // Host -> bus direction.
    bus_terminal_fifo_q #(.W(pckg_sz), .DEPTH(deep_fifo), .CW(cnt_w)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr_en),
        .wdata    (wr_data),
        .rd       (pop),
        .full     (tx_full),
        .count    (tx_count),
        .nonempty (pndng),
        .head     (D_pop),
        .ovf      (tx_ovf),
        .drop_cnt (tx_drop_cnt)
    );

    // Bus -> host direction; the RX full indication is not exported.
    bus_terminal_fifo_q #(.W(pckg_sz), .DEPTH(deep_fifo), .CW(cnt_w)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .wr       (push),
        .wdata    (D_push),
        .rd       (rx_rd),
        .full     (rx_full_s),
        .count    (rx_count),
        .nonempty (rx_valid),
        .head     (rx_data),
        .ovf      (rx_ovf),
        .drop_cnt (rx_drop_cnt)
    );

    logic unused_s;
    assign unused_s = rx_full_s;
endmodule
